// File: rtl/pr_scoreboard_ckpt_if.sv
// Scoreboard bus: allocation offers, retirement free/commit, flush and
// PRF writeback taps, plus the free count and the per-PR valid map.
interface pr_scoreboard_ckpt_if #(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int PR_ALLOC_PRTS     = 2,
  parameter int PR_FREE_PRTS      = 2,
  parameter int PR_COMMIT_PRTS    = 2,
  parameter int NUM_PRF_WR_PRTS   = 4
);
  localparam int PW = $clog2(NUM_PHYSICAL_REGS);
  localparam int CW = $clog2(NUM_PHYSICAL_REGS + 1);

  logic [PR_ALLOC_PRTS-1:0]            alloc_req;
  logic [PR_ALLOC_PRTS-1:0][PW-1:0]    alloc_reg;
  logic [PR_ALLOC_PRTS-1:0]            alloc_ok;
  logic [CW-1:0]                       free_cnt;
  logic [PR_FREE_PRTS-1:0]             free_pr;
  logic [PR_FREE_PRTS-1:0][PW-1:0]     pr_to_free;
  logic [PR_COMMIT_PRTS-1:0]           commit_pr;
  logic [PR_COMMIT_PRTS-1:0][PW-1:0]   commit_trgt;
  logic                                flush;
  logic [NUM_PRF_WR_PRTS-1:0]          prf_we;
  logic [NUM_PRF_WR_PRTS-1:0][PW-1:0]  prf_wr_trgt;
  logic [NUM_PHYSICAL_REGS-1:0]        pr_valid;

  modport master (
    output alloc_req, free_pr, pr_to_free, commit_pr, commit_trgt, flush,
           prf_we, prf_wr_trgt,
    input  alloc_reg, alloc_ok, free_cnt, pr_valid
  );

  modport slave (
    input  alloc_req, free_pr, pr_to_free, commit_pr, commit_trgt, flush,
           prf_we, prf_wr_trgt,
    output alloc_reg, alloc_ok, free_cnt, pr_valid
  );
endinterface

// File: rtl/pr_scoreboard_ckpt.sv
// Physical-register scoreboard: free list, data-valid and architectural bits
// per PR, pre-selected allocation offers and flush recovery.
// Optional macro SCOREBOARD_WB_BYPASS_EN: writebacks show up on pr_valid in
// the same cycle (combinational bypass); stored state is unaffected.
module pr_scoreboard_ckpt #(
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int NUM_ISA_REGS      = 19,
  parameter int PR_ALLOC_PRTS     = 2,
  parameter int PR_FREE_PRTS      = 2,
  parameter int PR_COMMIT_PRTS    = 2,
  parameter int NUM_PRF_WR_PRTS   = 4
) (
  input logic                    clk,
  input logic                    rst,
  pr_scoreboard_ckpt_if.slave    bus
);
  localparam int PW = $clog2(NUM_PHYSICAL_REGS);
  localparam int CW = $clog2(NUM_PHYSICAL_REGS + 1);

  typedef logic [NUM_PHYSICAL_REGS-1:0] map_t;

  // PRs below NUM_ISA_REGS hold the architectural registers out of reset
  localparam map_t ISA_MASK = {NUM_PHYSICAL_REGS{1'b1}} >> (NUM_PHYSICAL_REGS - NUM_ISA_REGS);

  map_t free_q, free_d;
  map_t arch_q, arch_d;
  map_t valid_q, valid_d;

  logic [PR_ALLOC_PRTS-1:0][PW-1:0] alloc_reg_q, alloc_reg_d;
  logic [PR_ALLOC_PRTS-1:0]         alloc_ok_q, alloc_ok_d;
  logic [CW-1:0]                    free_cnt_q, free_cnt_d;

  map_t avail;
  logic found;

  // Next-state maps: commit, then free, then alloc, then writeback, then flush mask
  always_comb begin
    free_d  = free_q;
    arch_d  = arch_q;
    valid_d = valid_q;
    for (int i = 0; i < PR_COMMIT_PRTS; i++)
      if (bus.commit_pr[i]) arch_d[bus.commit_trgt[i]] = 1'b1;
    for (int i = 0; i < PR_FREE_PRTS; i++)
      if (bus.free_pr[i]) begin
        free_d[bus.pr_to_free[i]]  = 1'b1;
        arch_d[bus.pr_to_free[i]]  = 1'b0;
        valid_d[bus.pr_to_free[i]] = 1'b0;
      end
    // allocations made in a flush cycle are discarded outright
    if (!bus.flush)
      for (int p = 0; p < PR_ALLOC_PRTS; p++)
        if (bus.alloc_req[p] && alloc_ok_q[p]) begin
          free_d[alloc_reg_q[p]]  = 1'b0;
          valid_d[alloc_reg_q[p]] = 1'b0;
          arch_d[alloc_reg_q[p]]  = 1'b0;
        end
    // a writeback to a PR that ends up free is dropped
    for (int k = 0; k < NUM_PRF_WR_PRTS; k++)
      if (bus.prf_we[k] && !free_d[bus.prf_wr_trgt[k]]) valid_d[bus.prf_wr_trgt[k]] = 1'b1;
    if (bus.flush) begin
      free_d  = free_d | ~arch_d;
      valid_d = valid_d & arch_d;
    end
  end

  // Offers: port p gets the (p+1)-th lowest free PR of the next-state map
  always_comb begin
    avail       = free_d;
    alloc_reg_d = '0;
    alloc_ok_d  = '0;
    found       = 1'b0;
    for (int p = 0; p < PR_ALLOC_PRTS; p++) begin
      found = 1'b0;
      for (int i = 0; i < NUM_PHYSICAL_REGS; i++)
        if (!found && avail[i]) begin
          found          = 1'b1;
          avail[i]       = 1'b0;
          alloc_reg_d[p] = PW'(i);
          alloc_ok_d[p]  = 1'b1;
        end
    end
  end

  // Free count is the popcount of the next-state free map
  always_comb begin
    free_cnt_d = '0;
    for (int i = 0; i < NUM_PHYSICAL_REGS; i++)
      free_cnt_d = free_cnt_d + CW'(free_d[i]);
  end

  // State and registered outputs; reset restores the ISA mapping asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_q     <= ~ISA_MASK;
      arch_q     <= ISA_MASK;
      valid_q    <= ISA_MASK;
      alloc_ok_q <= '1;
      free_cnt_q <= CW'(NUM_PHYSICAL_REGS - NUM_ISA_REGS);
      for (int p = 0; p < PR_ALLOC_PRTS; p++)
        alloc_reg_q[p] <= PW'(NUM_ISA_REGS + p);
    end else begin
      free_q      <= free_d;
      arch_q      <= arch_d;
      valid_q     <= valid_d;
      alloc_ok_q  <= alloc_ok_d;
      alloc_reg_q <= alloc_reg_d;
      free_cnt_q  <= free_cnt_d;
    end
  end

  assign bus.alloc_reg = alloc_reg_q;
  assign bus.alloc_ok  = alloc_ok_q;
  assign bus.free_cnt  = free_cnt_q;

`ifdef SCOREBOARD_WB_BYPASS_EN
  map_t wb_byp;

  // Same-cycle writeback hits on PRs that are currently allocated
  always_comb begin
    wb_byp = '0;
    for (int k = 0; k < NUM_PRF_WR_PRTS; k++)
      if (bus.prf_we[k] && !free_q[bus.prf_wr_trgt[k]]) wb_byp[bus.prf_wr_trgt[k]] = 1'b1;
  end

  assign bus.pr_valid = valid_q | wb_byp;
`else
  assign bus.pr_valid = valid_q;
`endif
endmodule

// File: tb/tb_pr_scoreboard_ckpt.sv
// Bench for pr_scoreboard_ckpt: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a behavioural model.
module tb_pr_scoreboard_ckpt;
  localparam int NPR = 64;
  localparam int ISA = 19;
  localparam int NA  = 2;
  localparam int NF  = 2;
  localparam int NC  = 2;
  localparam int NW  = 4;
  localparam int PW  = $clog2(NPR);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pr_scoreboard_ckpt_if #(.NUM_PHYSICAL_REGS(NPR), .PR_ALLOC_PRTS(NA), .PR_FREE_PRTS(NF),
                          .PR_COMMIT_PRTS(NC), .NUM_PRF_WR_PRTS(NW)) bus ();

  pr_scoreboard_ckpt #(.NUM_PHYSICAL_REGS(NPR), .NUM_ISA_REGS(ISA), .PR_ALLOC_PRTS(NA),
                       .PR_FREE_PRTS(NF), .PR_COMMIT_PRTS(NC), .NUM_PRF_WR_PRTS(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per-PR flags; offers and counts are derived from the free set
  bit m_free [NPR];
  bit m_arch [NPR];
  bit m_valid[NPR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPR; i++) begin
      m_free[i]  = (i >= ISA);
      m_arch[i]  = (i < ISA);
      m_valid[i] = (i < ISA);
    end
  endtask

  task automatic free_list(output int fl[$]);
    fl = {};
    for (int i = 0; i < NPR; i++) if (m_free[i]) fl.push_back(i);
  endtask

  // Apply one cycle of the retirement/alloc/writeback/flush rules to the model
  task automatic model_step();
    int fl[$];
    bit nf[NPR], na[NPR], nv[NPR];
    int t;
    free_list(fl);
    nf = m_free; na = m_arch; nv = m_valid;
    for (int i = 0; i < NC; i++) if (bus.commit_pr[i]) na[bus.commit_trgt[i]] = 1;
    for (int i = 0; i < NF; i++)
      if (bus.free_pr[i]) begin
        t = int'(bus.pr_to_free[i]);
        nf[t] = 1; na[t] = 0; nv[t] = 0;
      end
    if (!bus.flush)
      for (int p = 0; p < NA; p++)
        if (bus.alloc_req[p] && p < fl.size()) begin
          t = fl[p];
          nf[t] = 0; na[t] = 0; nv[t] = 0;
        end
    for (int k = 0; k < NW; k++)
      if (bus.prf_we[k] && !nf[bus.prf_wr_trgt[k]]) nv[bus.prf_wr_trgt[k]] = 1;
    if (bus.flush)
      for (int i = 0; i < NPR; i++) if (!na[i]) begin nf[i] = 1; nv[i] = 0; end
    m_free = nf; m_arch = na; m_valid = nv;
  endtask

  task automatic check_all();
    int fl[$];
    logic [NA-1:0][PW-1:0] e_reg;
    logic [NA-1:0]         e_ok;
    logic [NPR-1:0]        e_val;
    free_list(fl);
    e_reg = '0; e_ok = '0;
    for (int p = 0; p < NA; p++)
      if (p < fl.size()) begin e_reg[p] = PW'(fl[p]); e_ok[p] = 1'b1; end
    for (int i = 0; i < NPR; i++) e_val[i] = m_valid[i];
    chk("alloc_reg", 64'(bus.alloc_reg), 64'(e_reg));
    chk("alloc_ok",  64'(bus.alloc_ok),  64'(e_ok));
    chk("free_cnt",  64'(bus.free_cnt),  64'(fl.size()));
    chk("pr_valid",  64'(bus.pr_valid),  64'(e_val));
  endtask

  task automatic idle();
    bus.alloc_req = '0; bus.free_pr = '0; bus.pr_to_free = '0;
    bus.commit_pr = '0; bus.commit_trgt = '0; bus.flush = 1'b0;
    bus.prf_we = '0; bus.prf_wr_trgt = '0;
  endtask

  // One clock with whatever inputs are currently driven
  task automatic cycle();
`ifdef SCOREBOARD_WB_BYPASS_EN
    logic [NPR-1:0] e_byp;
    #1;
    for (int i = 0; i < NPR; i++) e_byp[i] = m_valid[i];
    for (int k = 0; k < NW; k++)
      if (bus.prf_we[k] && !m_free[bus.prf_wr_trgt[k]]) e_byp[bus.prf_wr_trgt[k]] = 1'b1;
    chk("pr_valid_byp", 64'(bus.pr_valid), 64'(e_byp));
`endif
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
    check_all();
  endtask

  task automatic chk_reset_lits(input string tag);
    chk({tag, "_reg"}, 64'(bus.alloc_reg), 64'({6'd20, 6'd19}));
    chk({tag, "_ok"},  64'(bus.alloc_ok),  64'd3);
    chk({tag, "_cnt"}, 64'(bus.free_cnt),  64'd45);
    chk({tag, "_val"}, 64'(bus.pr_valid),  64'h7FFFF);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nonfree[$];
    idle();
    model_reset();
    #12;
    chk_reset_lits("in_reset");
    @(negedge clk);
    rst = 1'b1;
    chk_reset_lits("released");
    check_all();

    // three back-to-back double allocations consume PRs 19..24
    bus.alloc_req = 2'b11;
    repeat (3) cycle();
    idle();
    chk("burst_reg", 64'(bus.alloc_reg), 64'({6'd26, 6'd25}));
    chk("burst_cnt", 64'(bus.free_cnt), 64'd39);
    chk("burst_val", 64'(bus.pr_valid), 64'h7FFFF);

    // allocate 19, then write it back
    do_reset();
    bus.alloc_req = 2'b01;
    cycle();
    idle();
    chk("wb_before", 64'(bus.pr_valid[19]), 64'd0);
    bus.prf_we = 4'b0100;
    bus.prf_wr_trgt[2] = PW'(19);
`ifdef SCOREBOARD_WB_BYPASS_EN
    #1;
    chk("wb_same_cycle", 64'(bus.pr_valid[19]), 64'd1);
`endif
    cycle();
    idle();
    chk("wb_after", 64'(bus.pr_valid[19]), 64'd1);

    // allocate 19..22, commit 19/20, flush with a concurrent alloc request
    do_reset();
    bus.alloc_req = 2'b11;
    repeat (2) cycle();
    idle();
    bus.commit_pr = 2'b11;
    bus.commit_trgt[0] = PW'(19);
    bus.commit_trgt[1] = PW'(20);
    cycle();
    idle();
    bus.flush = 1'b1;
    bus.alloc_req = 2'b11;
    cycle();
    idle();
    chk("flush_reg", 64'(bus.alloc_reg), 64'({6'd22, 6'd21}));
    chk("flush_cnt", 64'(bus.free_cnt), 64'd43);

    // double free of 19 plus a writeback to free PR 30
    bus.free_pr = 2'b11;
    bus.pr_to_free[0] = PW'(19);
    bus.pr_to_free[1] = PW'(19);
    bus.prf_we = 4'b0001;
    bus.prf_wr_trgt[0] = PW'(30);
    cycle();
    idle();
    chk("dbl_free_cnt", 64'(bus.free_cnt), 64'd44);
    chk("wb_to_free", 64'(bus.pr_valid[30]), 64'd0);
    chk("dbl_free_reg", 64'(bus.alloc_reg), 64'({6'd21, 6'd19}));

    // randomized traffic
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      idle();
      nonfree = {};
      for (int i = 0; i < NPR; i++) if (!m_free[i]) nonfree.push_back(i);
      bus.alloc_req = NA'($urandom);
      for (int i = 0; i < NF; i++)
        if ($urandom_range(0, 2) == 0) begin
          bus.free_pr[i] = 1'b1;
          bus.pr_to_free[i] = PW'($urandom_range(0, NPR - 1));
        end
      for (int i = 0; i < NC; i++)
        if (nonfree.size() > 0 && $urandom_range(0, 3) == 0) begin
          bus.commit_pr[i] = 1'b1;
          bus.commit_trgt[i] = PW'(nonfree[$urandom_range(0, nonfree.size() - 1)]);
        end
      for (int k = 0; k < NW; k++)
        if ($urandom_range(0, 1) == 0) begin
          bus.prf_we[k] = 1'b1;
          bus.prf_wr_trgt[k] = PW'($urandom_range(0, NPR - 1));
        end
      bus.flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    idle();

    // drain the pool to one, then zero free PRs
    do_reset();
    bus.alloc_req = 2'b11;
    repeat (22) cycle();
    idle();
    chk("drain1_ok",  64'(bus.alloc_ok), 64'd1);
    chk("drain1_cnt", 64'(bus.free_cnt), 64'd1);
    chk("drain1_reg", 64'(bus.alloc_reg), 64'({6'd0, 6'd63}));
    bus.alloc_req = 2'b01;
    cycle();
    idle();
    chk("drain0_ok",  64'(bus.alloc_ok), 64'd0);
    chk("drain0_cnt", 64'(bus.free_cnt), 64'd0);
    bus.alloc_req = 2'b11;
    cycle();
    chk("empty_ok",  64'(bus.alloc_ok), 64'd0);
    chk("empty_cnt", 64'(bus.free_cnt), 64'd0);
    chk("empty_reg", 64'(bus.alloc_reg), 64'd0);

    // asynchronous reset in the middle of an allocation burst
    do_reset();
    bus.alloc_req = 2'b11;
    repeat (2) cycle();
    #2;
    rst = 1'b0;
    #1;
    chk_reset_lits("async_rst");
    model_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
